led_bank_ctrl: RTL and testbench
================================

// Module: led_bank_ctrl
// PURPOSE
//   Parametrised LED-bank driver: latches a value and a display mode on a load
//   strobe, then drives N_LEDS outputs as direct, bar graph, blink or rotate
//   pattern, gated by a global PWM brightness. Sits between the counter/value
//   source and the board LED pins; replaces the plain 8-bit pass-through driver.
// PARAMETERS
//   N_LEDS     8           number of LED outputs, >=2
//   PWM_BITS   4           brightness / PWM counter width, >=1
//   BLINK_DIV  25_000_000  clk cycles per blink/rotate tick, >=1
// PORTS
//   clk         in   1          system clock, all logic on rising edge
//   rst         in   1          asynchronous reset, active-high
//   load        in   1          1-cycle strobe: capture value and mode
//   value       in   N_LEDS     pattern (direct/blink/rotate) or count (bar)
//   mode        in   2          0 DIRECT, 1 BAR, 2 BLINK, 3 ROTATE
//   brightness  in   PWM_BITS   global duty, 0 = off, all-ones = fully on
//   leds        out  N_LEDS     registered LED drive, 1 = lit
// BEHAVIOUR
// - Reset (async, immediate): leds=0, shadow value=0, mode_r=DIRECT, rot=0,
//   div_cnt=0, blink_ph=1, pwm_cnt=0, bright_r=0.
// - Capture: load=1 at edge t -> shadow=value, mode_r=mode, rot=value,
//   div_cnt=0, blink_ph=1 at t+1. value/mode ignored while load=0.
// - Latency: pattern is registered into leds one cycle after capture; leds
//   show new pattern at edge t+2 (subject to PWM gate).
// - Divider: div_cnt counts 0..BLINK_DIV-1, wraps to 0; tick=1 in the cycle
//   div_cnt==BLINK_DIV-1. BLINK_DIV=1 -> tick every cycle. Load restarts it.
// - Pattern by mode_r:
//   DIRECT: shadow.
//   BAR:    leds[i]=1 iff i < shadow (unsigned); shadow=0 -> none,
//           shadow>=N_LEDS -> all lit.
//   BLINK:  shadow when blink_ph=1 else 0; blink_ph toggles on tick.
//   ROTATE: rot; on tick rot rotates left by 1, rot[N_LEDS-1] -> rot[0].
//           rot=0 or all-ones stays constant.
// - Load and tick in same cycle: load wins (restart, no toggle/rotate).
// - PWM: pwm_cnt free-running 0..2^PWM_BITS-1, wraps. bright_r<=brightness
//   only when pwm_cnt==all-ones (update at period boundary, no mid-period
//   glitch). pwm_en = (bright_r==all-ones) | (pwm_cnt < bright_r).
//   bright_r=0 -> leds stay 0; all-ones -> 100% duty; else bright_r/2^PWM_BITS.
// - leds <= pattern & {N_LEDS{pwm_en}} every cycle (single output register).
// - Mode change only via load; brightness changes never affect shadow/rot.
// - Reset asserted mid-blink/rotate/PWM: all state cleared at once; after
//   release, leds=0 until a load and a nonzero bright_r take effect.
// TESTING (N_LEDS=8, PWM_BITS=2, BLINK_DIV=4)
// 1 Reset release, brightness=3, load value=0xA5 mode=0 -> leds=0xA5 from
//   2nd edge after PWM update, steady thereafter.
// 2 mode=1, value=3 -> leds=0x07; value=0 -> 0x00; value=9 -> 0xFF.
// 3 mode=2 value=0x0F, brightness=3 -> leds 0x0F for 4 cycles, 0x00 for 4,
//   repeating; load mid-off-phase -> on-phase restarts at load.
// 4 mode=3 value=0x81 -> 0x81, 0x03, 0x06, 0x0C ... one step per 4 cycles;
//   load coincident with tick -> rot=new value, no rotation that cycle.
// 5 DIRECT 0xFF, brightness=1 -> leds=0xFF exactly 1 of every 4 cycles;
//   brightness=0 -> all 0; change applied only at pwm_cnt wrap.
// 6 Assert rst mid-ROTATE (async, between edges) -> leds=0 immediately,
//   stays 0 after release until load + brightness>0.

Source files
------------

// File: rtl/led_bank_ctrl.sv
// led_bank_ctrl: LED-bank driver.
//   On a one-cycle load strobe it captures a value and a display mode, then
//   drives N_LEDS outputs as a direct pattern, a bar graph, a blinking
//   pattern or a rotating pattern. A global PWM brightness gates all outputs.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   load       1-cycle strobe, captures value and mode
//   value      pattern (direct/blink/rotate) or lit count (bar)
//   mode       0 DIRECT, 1 BAR, 2 BLINK, 3 ROTATE
//   brightness global duty, 0 = off, all-ones = fully on
//   leds       registered LED drive, 1 = lit

package led_bank_pkg;
  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_BAR    = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_ROTATE = 2'd3
  } mode_e;
endpackage

// led_bank_lane: pattern select and output flop for one LED.
//   mode      latched display mode
//   shadow    latched value (whole vector, needed for the bar compare)
//   rot_bit   this lane's bit of the rotate register
//   blink_ph  blink phase, 1 = on
//   pwm_en    PWM gate for the current cycle
//   led       registered drive for this LED
module led_bank_lane
  import led_bank_pkg::*;
#(
  parameter int N_LEDS = 8,
  parameter int IDX    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  mode_e             mode,
  input  logic [N_LEDS-1:0] shadow,
  input  logic              rot_bit,
  input  logic              blink_ph,
  input  logic              pwm_en,
  output logic              led
);
  // Lane index at shadow width; IDX <= N_LEDS-1 always fits.
  localparam logic [N_LEDS-1:0] IDX_V = N_LEDS'(IDX);

  logic pat;
  logic led_d, led_q;

  always_comb begin
    pat = 1'b0;
    case (mode)
      MODE_DIRECT: pat = shadow[IDX];
      // Bar: lanes below the count are lit; counts >= N_LEDS light all.
      MODE_BAR:    pat = (IDX_V < shadow);
      MODE_BLINK:  pat = shadow[IDX] & blink_ph;
      MODE_ROTATE: pat = rot_bit;
      default:     pat = 1'b0;
    endcase
    led_d = pat & pwm_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_q <= 1'b0;
    else     led_q <= led_d;
  end

  assign led = led_q;
endmodule

module led_bank_ctrl
  import led_bank_pkg::*;
#(
  parameter int N_LEDS    = 8,
  parameter int PWM_BITS  = 4,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [N_LEDS-1:0]   value,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LEDS-1:0]   leds
);
  localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_MAX = DIV_W'(BLINK_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [N_LEDS-1:0]   shadow_d, shadow_q;
  mode_e               mode_d, mode_q;
  logic [N_LEDS-1:0]   rot_d, rot_q;
  logic [DIV_W-1:0]    div_cnt_d, div_cnt_q;
  logic                blink_ph_d, blink_ph_q;
  logic [PWM_BITS-1:0] pwm_cnt_d, pwm_cnt_q;
  logic [PWM_BITS-1:0] bright_d, bright_q;
  logic                tick;
  logic                pwm_en;

  // With BLINK_DIV=1 the counter is pinned at 0, so this fires every cycle.
  assign tick = (div_cnt_q == DIV_MAX);

  always_comb begin
    shadow_d   = shadow_q;
    mode_d     = mode_q;
    rot_d      = rot_q;
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    blink_ph_d = tick ? ~blink_ph_q : blink_ph_q;
    if (tick) rot_d = {rot_q[N_LEDS-2:0], rot_q[N_LEDS-1]};

    // Load overrides a coincident tick: restart divider and phase, no step.
    if (load) begin
      shadow_d   = value;
      mode_d     = mode_e'(mode);
      rot_d      = value;
      div_cnt_d  = '0;
      blink_ph_d = 1'b1;
    end

    pwm_cnt_d = pwm_cnt_q + 1'b1;
    // Brightness is only sampled at the PWM period boundary so a change
    // never produces a truncated or stretched pulse.
    bright_d  = (pwm_cnt_q == PWM_MAX) ? brightness : bright_q;

    // All-ones must be 100% duty, which the plain compare cannot reach.
    pwm_en = (bright_q == PWM_MAX) | (pwm_cnt_q < bright_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= '0;
      mode_q     <= MODE_DIRECT;
      rot_q      <= '0;
      div_cnt_q  <= '0;
      blink_ph_q <= 1'b1;
      pwm_cnt_q  <= '0;
      bright_q   <= '0;
    end else begin
      shadow_q   <= shadow_d;
      mode_q     <= mode_d;
      rot_q      <= rot_d;
      div_cnt_q  <= div_cnt_d;
      blink_ph_q <= blink_ph_d;
      pwm_cnt_q  <= pwm_cnt_d;
      bright_q   <= bright_d;
    end
  end

  // One lane per LED; each lane holds its own output flop.
  for (genvar i = 0; i < N_LEDS; i++) begin : g_lane
    led_bank_lane #(
      .N_LEDS (N_LEDS),
      .IDX    (i)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode_q),
      .shadow   (shadow_q),
      .rot_bit  (rot_q[i]),
      .blink_ph (blink_ph_q),
      .pwm_en   (pwm_en),
      .led      (leds[i])
    );
  end
endmodule

// File: tb/tb_led_bank_ctrl.sv
// Bench for led_bank_ctrl (N_LEDS=8, PWM_BITS=2, BLINK_DIV=4).
// cyc counts rising edges since reset release; the entry for cycle k is the
// leds value visible after edge k, compared on the following falling edge.
module tb_led_bank_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] value = 8'h00;
  logic [1:0] mode = 2'd0;
  logic [1:0] brightness = 2'd3;
  logic [7:0] leds;

  always #5 clk = ~clk;

  led_bank_ctrl #(
    .N_LEDS    (8),
    .PWM_BITS  (2),
    .BLINK_DIV (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .mode       (mode),
    .brightness (brightness),
    .leds       (leds)
  );

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: leds=%02h expected %02h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops every expectation due at this cycle.
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc == cyc) chk(e.name, leds, e.val);
        else begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_rng(input int a, input int b, input logic [7:0] v, input string nm);
    for (int k = a; k <= b; k++) q.push_back('{k, v, nm});
  endtask

  // Called at a falling edge; load is sampled on the next rising edge.
  task automatic do_load(input logic [7:0] v, input logic [1:0] m);
    load  = 1'b1;
    value = v;
    mode  = m;
    @(negedge clk);
    load  = 1'b0;
    value = 8'($urandom);
    mode  = 2'($urandom);
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    summary();
    $fatal(1);
  end

  initial begin
    int c, d;
    step(2);
    chk("reset_leds", leds, 8'h00);

    // 1: release, DIRECT 0xA5; bright_r becomes 3 at edge 4
    rst = 1'b0;
    expect_rng(1, 4, 8'h00, "t1_pwm_not_yet");
    expect_rng(5, 12, 8'hA5, "t1_direct");
    do_load(8'hA5, 2'd0);
    step(11);

    // 2: BAR
    c = cyc; expect_rng(c+2, c+5, 8'h07, "t2_bar3");
    do_load(8'd3, 2'd1); step(5);
    c = cyc; expect_rng(c+2, c+5, 8'h00, "t2_bar0");
    do_load(8'd0, 2'd1); step(5);
    c = cyc; expect_rng(c+2, c+5, 8'hFF, "t2_bar9");
    do_load(8'd9, 2'd1); step(5);

    // 3: BLINK, then reload in the off phase
    c = cyc;
    expect_rng(c+2,  c+5,  8'h0F, "t3_on");
    expect_rng(c+6,  c+9,  8'h00, "t3_off");
    expect_rng(c+10, c+13, 8'h0F, "t3_on2");
    expect_rng(c+14, c+16, 8'h00, "t3_off2");
    do_load(8'h0F, 2'd2);
    step(14);
    expect_rng(c+17, c+20, 8'h0F, "t3_restart_on");
    expect_rng(c+21, c+24, 8'h00, "t3_restart_off");
    do_load(8'h0F, 2'd2);
    step(8);

    // 4: ROTATE, then load coincident with a tick
    c = cyc;
    expect_rng(c+2,  c+5,  8'h81, "t4_rot0");
    expect_rng(c+6,  c+9,  8'h03, "t4_rot1");
    expect_rng(c+10, c+13, 8'h06, "t4_rot2");
    expect_rng(c+14, c+17, 8'h0C, "t4_rot3");
    do_load(8'h81, 2'd3);
    step(15);
    expect_rng(c+18, c+21, 8'h11, "t4_load_on_tick");
    expect_rng(c+22, c+25, 8'h22, "t4_rot_after");
    do_load(8'h11, 2'd3);
    step(8);

    // 5: PWM duty 1/4, change only at the pwm_cnt wrap
    c = cyc;
    expect_rng(c+2, c+5, 8'hFF, "t5_full");
    do_load(8'hFF, 2'd0);
    step(4);
    while (cyc % 4 != 2) step(1);
    d = cyc;
    brightness = 2'd1;
    expect_rng(d+1, d+2, 8'hFF, "t5_hold_to_wrap");
    for (int j = 3; j <= 18; j++)
      expect_rng(d+j, d+j, ((d+j) % 4 == 1) ? 8'hFF : 8'h00, "t5_duty_1of4");
    step(20);
    d = cyc;
    brightness = 2'd0;
    expect_rng(d+1, d+10, 8'h00, "t5_bright0");
    step(10);

    // 6: async reset mid-ROTATE
    brightness = 2'd3;
    step(4);
    c = cyc;
    expect_rng(c+2, c+5, 8'h81, "t6_rot");
    do_load(8'h81, 2'd3);
    step(6);
    chk("t6_pre_reset_lit", leds, 8'h03);
    #2 rst = 1'b1;
    #1 chk("t6_async_clear", leds, 8'h00);
    q.delete();
    step(3);
    chk("t6_held_in_reset", leds, 8'h00);
    rst = 1'b0;
    expect_rng(1, 10, 8'h00, "t6_dark_until_load");
    step(10);
    c = cyc;
    expect_rng(c+2, c+5, 8'h5A, "t6_reload");
    do_load(8'h5A, 2'd0);
    step(6);

    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    summary();
    $finish;
  end
endmodule
